bp_nonsynth_bedrock_stream_monitor: RTL and testbench

- Nonsynth runtime protocol monitor; sits alongside and downstream of the static interface/parameter check, observing live BedRock mem_fwd/mem_rev streams between a CCE/UCE and memory.
- Checks ready_and/valid handshake legality, header stability, beat count against msg_size, and fwd/rev outstanding balance with a timeout.
- Drives sticky error flags and an outstanding count, and prints $error messages. Passive: it never back-pressures the stream.

---
 rtl/bp_nonsynth_mon_pkg.sv | 39 +++
 rtl/bp_nonsynth_bedrock_chan_checker.sv | 91 +++++++++
 rtl/bp_nonsynth_bedrock_stream_monitor.sv | 131 +++++++++++++
 tb/tb_bp_nonsynth_bedrock_stream_monitor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_nonsynth_mon_pkg.sv
// rtl/bp_nonsynth_mon_pkg.sv - shared types and beat math for the BedRock stream monitor
package bp_nonsynth_mon_pkg;

    typedef enum logic [2:0] {
        e_err_valid_drop   = 3'd0,
        e_err_hdr_unstable = 3'd1,
        e_err_last         = 3'd2,
        e_err_underflow    = 3'd3,
        e_err_overflow     = 3'd4,
        e_err_timeout      = 3'd5
    } bp_nonsynth_mon_err_e;

    typedef enum logic [1:0] {
        e_idle,
        e_stall,
        e_mid
    } bp_nonsynth_chan_state_e;

    localparam int mon_err_width_lp = 6;
    localparam int beat_width_lp    = 11;

    // Message bits (8 << size) shifted down by log2(data width); header-only messages are one beat.
    function automatic logic [beat_width_lp-1:0] expected_beats(
        input logic [2:0] size,
        input logic       has_data,
        input int         beat_shift
    );
        logic [beat_width_lp-1:0] msg_bits;
        logic [beat_width_lp-1:0] beats;
        msg_bits = beat_width_lp'(8) << size;
        beats    = msg_bits >> beat_shift;
        if (!has_data || (beats == '0)) begin
            expected_beats = beat_width_lp'(1);
        end else begin
            expected_beats = beats;
        end
    endfunction

endpackage

// File: rtl/bp_nonsynth_bedrock_chan_checker.sv
// rtl/bp_nonsynth_bedrock_chan_checker.sv - per-channel handshake, header stability and beat-count checker
module bp_nonsynth_bedrock_chan_checker
    import bp_nonsynth_mon_pkg::*;
#(
    parameter int data_width_p   = 64,
    parameter int header_width_p = 128
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic [header_width_p-1:0] header_i,
    input  logic [2:0]                size_i,
    input  logic                      has_data_i,
    input  logic                      last_i,
    input  logic                      v_i,
    input  logic                      ready_and_i,
    output logic                      done_o,
    output logic [2:0]                err_o
);

    localparam int beat_shift_lp = $clog2(data_width_p);

    bp_nonsynth_chan_state_e   state_r;
    logic [beat_width_lp-1:0]  beat_r;
    logic [header_width_p-1:0] hdr_r;

    logic                     hs;
    logic [beat_width_lp-1:0] expected;
    logic [beat_width_lp-1:0] cur_beat;
    logic [beat_width_lp-1:0] next_beat;
    logic                     hdr_diff;
    logic                     drop;
    logic                     last_err;

    // Idle and stall both count as "beat 0", so one last-beat rule covers every state.
    always_comb begin
        hs        = v_i & ready_and_i;
        expected  = expected_beats(size_i, has_data_i, beat_shift_lp);
        cur_beat  = (state_r == e_mid) ? beat_r : '0;
        next_beat = cur_beat + beat_width_lp'(1);
        hdr_diff  = v_i & (state_r != e_idle) & (header_i != hdr_r);
        drop      = (state_r == e_stall) & ~v_i;
        last_err  = hs & (last_i ? (next_beat != expected) : (next_beat == expected));
        done_o    = hs & last_i;
        err_o     = {last_err, hdr_diff, drop};
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r <= e_idle;
            beat_r  <= '0;
            hdr_r   <= '0;
        end else begin
            case (state_r)
                e_idle: begin
                    if (hs) begin
                        if (!last_i) begin
                            state_r <= e_mid;
                            beat_r  <= beat_width_lp'(1);
                            hdr_r   <= header_i;
                        end
                    end else if (v_i) begin
                        state_r <= e_stall;
                        hdr_r   <= header_i;
                    end
                end
                e_stall: begin
                    if (!v_i) begin
                        state_r <= e_idle;
                    end else if (hs && !last_i) begin
                        state_r <= e_mid;
                        beat_r  <= beat_width_lp'(1);
                    end else if (hs) begin
                        state_r <= e_idle;
                    end
                end
                e_mid: begin
                    if (hs) begin
                        if (last_i) begin
                            state_r <= e_idle;
                            beat_r  <= '0;
                        end else begin
                            beat_r  <= next_beat;
                        end
                    end
                end
                default: state_r <= e_idle;
            endcase
        end
    end

endmodule

// File: rtl/bp_nonsynth_bedrock_stream_monitor.sv
// rtl/bp_nonsynth_bedrock_stream_monitor.sv - passive mem_fwd/mem_rev protocol monitor with sticky error flags
module bp_nonsynth_bedrock_stream_monitor
    import bp_nonsynth_mon_pkg::*;
#(
    parameter int data_width_p      = 64,
    parameter int header_width_p    = 128,
    parameter int max_outstanding_p = 8,
    parameter int timeout_p         = 4096,
    localparam int ptr_width_lp     = $clog2(max_outstanding_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic                        en_i,
    input  logic [header_width_p-1:0]   fwd_header_i,
    input  logic [2:0]                  fwd_size_i,
    input  logic                        fwd_has_data_i,
    input  logic                        fwd_last_i,
    input  logic                        fwd_v_i,
    input  logic                        fwd_ready_and_i,
    input  logic [header_width_p-1:0]   rev_header_i,
    input  logic [2:0]                  rev_size_i,
    input  logic                        rev_has_data_i,
    input  logic                        rev_last_i,
    input  logic                        rev_v_i,
    input  logic                        rev_ready_and_i,
    output logic [mon_err_width_lp-1:0] err_o,
    output logic [ptr_width_lp-1:0]     outstanding_o,
    output logic                        timeout_o
);

    localparam int tcnt_width_lp = $clog2(timeout_p + 1);

    logic                        fwd_done, rev_done;
    logic [2:0]                  fwd_err, rev_err;
    logic [mon_err_width_lp-1:0] err_ev;
    logic [mon_err_width_lp-1:0] err_prev_r;
    logic [ptr_width_lp-1:0]     out_n;
    logic [tcnt_width_lp-1:0]    tcnt_r, tcnt_n;

    bp_nonsynth_bedrock_chan_checker #(
        .data_width_p  (data_width_p),
        .header_width_p(header_width_p)
    ) fwd_chk (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .header_i   (fwd_header_i),
        .size_i     (fwd_size_i),
        .has_data_i (fwd_has_data_i),
        .last_i     (fwd_last_i),
        .v_i        (fwd_v_i),
        .ready_and_i(fwd_ready_and_i),
        .done_o     (fwd_done),
        .err_o      (fwd_err)
    );

    bp_nonsynth_bedrock_chan_checker #(
        .data_width_p  (data_width_p),
        .header_width_p(header_width_p)
    ) rev_chk (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .header_i   (rev_header_i),
        .size_i     (rev_size_i),
        .has_data_i (rev_has_data_i),
        .last_i     (rev_last_i),
        .v_i        (rev_v_i),
        .ready_and_i(rev_ready_and_i),
        .done_o     (rev_done),
        .err_o      (rev_err)
    );

    always_comb begin
        err_ev      = '0;
        err_ev[2:0] = fwd_err | rev_err;
        out_n       = outstanding_o;
        tcnt_n      = tcnt_r;
        case ({fwd_done, rev_done})
            2'b10: begin
                if (outstanding_o == ptr_width_lp'(max_outstanding_p)) begin
                    err_ev[e_err_overflow] = 1'b1;
                end else begin
                    out_n = outstanding_o + ptr_width_lp'(1);
                end
            end
            2'b01: begin
                if (outstanding_o == '0) begin
                    err_ev[e_err_underflow] = 1'b1;
                end else begin
                    out_n = outstanding_o - ptr_width_lp'(1);
                end
            end
            2'b11: err_ev[e_err_underflow] = (outstanding_o == '0);
            default: ;
        endcase
        // The timeout flag is raised on the same edge the counter reaches its limit.
        if (rev_done || (outstanding_o == '0)) begin
            tcnt_n = '0;
        end else if (tcnt_r != tcnt_width_lp'(timeout_p)) begin
            tcnt_n = tcnt_r + tcnt_width_lp'(1);
            err_ev[e_err_timeout] = (tcnt_r == tcnt_width_lp'(timeout_p - 1));
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            err_o         <= '0;
            outstanding_o <= '0;
            tcnt_r        <= '0;
        end else begin
            err_o         <= err_o | err_ev;
            outstanding_o <= out_n;
            tcnt_r        <= tcnt_n;
        end
    end

    assign timeout_o = err_o[e_err_timeout];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            err_prev_r <= '0;
        end else begin
            err_prev_r <= err_o;
            for (int i = 0; i < mon_err_width_lp; i++) begin
                if (en_i && err_o[i] && !err_prev_r[i]) begin
                    $error("bedrock stream monitor: error bit %0d raised", i);
                end
            end
        end
    end

endmodule

// File: tb/tb_bp_nonsynth_bedrock_stream_monitor.sv
// tb/tb_bp_nonsynth_bedrock_stream_monitor.sv - directed self-checking bench for the BedRock stream monitor
module tb_bp_nonsynth_bedrock_stream_monitor;

    localparam int dw_lp  = 64;
    localparam int hw_lp  = 128;
    localparam int max_lp = 8;
    localparam int to_lp  = 16;
    localparam int pw_lp  = $clog2(max_lp + 1);

    logic             clk = 1'b0;
    logic             reset_ni;
    logic             en;
    logic [hw_lp-1:0] fwd_header, rev_header;
    logic [2:0]       fwd_size, rev_size;
    logic             fwd_has_data, fwd_last, fwd_v, fwd_ready_and;
    logic             rev_has_data, rev_last, rev_v, rev_ready_and;
    logic [5:0]       err;
    logic [pw_lp-1:0] outstanding;
    logic             timeout;

    int compared   = 0;
    int mismatched = 0;

    bp_nonsynth_bedrock_stream_monitor #(
        .data_width_p     (dw_lp),
        .header_width_p   (hw_lp),
        .max_outstanding_p(max_lp),
        .timeout_p        (to_lp)
    ) dut (
        .clk_i          (clk),
        .reset_ni       (reset_ni),
        .en_i           (en),
        .fwd_header_i   (fwd_header),
        .fwd_size_i     (fwd_size),
        .fwd_has_data_i (fwd_has_data),
        .fwd_last_i     (fwd_last),
        .fwd_v_i        (fwd_v),
        .fwd_ready_and_i(fwd_ready_and),
        .rev_header_i   (rev_header),
        .rev_size_i     (rev_size),
        .rev_has_data_i (rev_has_data),
        .rev_last_i     (rev_last),
        .rev_v_i        (rev_v),
        .rev_ready_and_i(rev_ready_and),
        .err_o          (err),
        .outstanding_o  (outstanding),
        .timeout_o      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fwd_v = 1'b0; fwd_ready_and = 1'b0; fwd_last = 1'b0;
        rev_v = 1'b0; rev_ready_and = 1'b0; rev_last = 1'b0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        reset_ni = 1'b0;
        #2;
        reset_ni = 1'b1;
    endtask

    task automatic drive_fwd(input logic [2:0] size, input logic has_data, input logic last,
                             input logic [hw_lp-1:0] hdr);
        fwd_v = 1'b1; fwd_ready_and = 1'b1;
        fwd_size = size; fwd_has_data = has_data; fwd_last = last; fwd_header = hdr;
    endtask

    task automatic drive_rev();
        rev_v = 1'b1; rev_ready_and = 1'b1;
        rev_size = 3'd3; rev_has_data = 1'b0; rev_last = 1'b1; rev_header = 128'h5;
    endtask

    initial begin
        logic [hw_lp-1:0] h;
        h = 128'hA5A5_0000_1111_2222_3333_4444_5555_6660;
        reset_ni = 1'b0;
        en = 1'b0;
        fwd_header = '0; rev_header = '0;
        fwd_size = '0; rev_size = '0;
        fwd_has_data = 1'b0; rev_has_data = 1'b0;
        idle_inputs();
        step();
        check("reset_err", 32'(err), 32'h0);
        check("reset_outstanding", 32'(outstanding), 32'h0);
        check("reset_timeout", 32'(timeout), 32'h0);
        reset_ni = 1'b1;

        // 64B write, 8 beats, then a single-beat response
        for (int i = 1; i <= 8; i++) begin
            drive_fwd(3'd6, 1'b1, (i == 8), h);
            step();
            if (i == 7) check("write_beat7_outstanding", 32'(outstanding), 32'h0);
        end
        idle_inputs();
        check("write_done_outstanding", 32'(outstanding), 32'h1);
        check("write_done_err", 32'(err), 32'h0);
        drive_rev();
        step();
        idle_inputs();
        check("rev_done_outstanding", 32'(outstanding), 32'h0);
        check("rev_done_err", 32'(err), 32'h0);

        // Same write terminated early on beat 5
        pulse_reset();
        for (int i = 1; i <= 5; i++) begin
            drive_fwd(3'd6, 1'b1, (i == 5), h);
            step();
        end
        idle_inputs();
        check("short_write_err", 32'(err), 32'h04);
        check("short_write_outstanding", 32'(outstanding), 32'h1);

        // Stalled valid with header glitch, then valid dropped before handshake
        pulse_reset();
        fwd_v = 1'b1; fwd_ready_and = 1'b0; fwd_header = h;
        fwd_size = 3'd6; fwd_has_data = 1'b1;
        step();
        fwd_header = h ^ 128'h1;
        step();
        check("hdr_unstable_err", 32'(err), 32'h02);
        fwd_header = h;
        step();
        check("hdr_unstable_sticky", 32'(err), 32'h02);
        fwd_v = 1'b0;
        step();
        check("valid_drop_err", 32'(err), 32'h03);
        check("valid_drop_outstanding", 32'(outstanding), 32'h0);

        // Response with nothing outstanding
        pulse_reset();
        drive_rev();
        step();
        idle_inputs();
        check("underflow_err", 32'(err), 32'h08);
        check("underflow_outstanding", 32'(outstanding), 32'h0);

        // Two reads outstanding, then simultaneous fwd and rev completion
        pulse_reset();
        for (int i = 0; i < 2; i++) begin
            drive_fwd(3'd3, 1'b0, 1'b1, h);
            step();
        end
        idle_inputs();
        check("two_out_outstanding", 32'(outstanding), 32'h2);
        drive_fwd(3'd3, 1'b0, 1'b1, h);
        drive_rev();
        step();
        idle_inputs();
        check("both_done_outstanding", 32'(outstanding), 32'h2);
        check("both_done_err", 32'(err), 32'h0);

        // Nine reads with no responses
        pulse_reset();
        for (int i = 1; i <= 9; i++) begin
            drive_fwd(3'd3, 1'b0, 1'b1, h);
            step();
            if (i == 8) begin
                check("eight_out_outstanding", 32'(outstanding), 32'h8);
                check("eight_out_err", 32'(err), 32'h0);
            end
        end
        idle_inputs();
        check("overflow_err", 32'(err), 32'h10);
        check("overflow_outstanding", 32'(outstanding), 32'h8);

        // Timeout boundary: one read, then silence
        pulse_reset();
        drive_fwd(3'd3, 1'b0, 1'b1, h);
        step();
        idle_inputs();
        for (int i = 0; i < 15; i++) step();
        check("timeout_before_limit", 32'(timeout), 32'h0);
        step();
        check("timeout_at_limit", 32'(timeout), 32'h1);
        check("timeout_err", 32'(err), 32'h20);

        // Asynchronous reset in the middle of a multi-beat write
        for (int i = 0; i < 3; i++) begin
            drive_fwd(3'd6, 1'b1, 1'b0, h);
            step();
        end
        reset_ni = 1'b0;
        #1;
        check("async_reset_err", 32'(err), 32'h0);
        check("async_reset_outstanding", 32'(outstanding), 32'h0);
        check("async_reset_timeout", 32'(timeout), 32'h0);
        idle_inputs();
        reset_ni = 1'b1;
        step();
        drive_fwd(3'd3, 1'b0, 1'b1, h);
        step();
        idle_inputs();
        check("post_reset_outstanding", 32'(outstanding), 32'h1);
        check("post_reset_err", 32'(err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
